// File: rtl/mem_dma.sv
// mem_dma: shares mem read port 1 and the write port between the CPU and a fill/copy DMA.
// Optional DMA_BACKWARD_EN: copies with dst > src run descending (memmove semantics).
`timescale 1ns/1ps
module mem_dma (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ren,
   input  logic [15:0] cpu_raddr,
   input  logic        cpu_wen,
   input  logic [15:0] cpu_waddr,
   input  logic [15:0] cpu_wdata,
   output logic        mem_ren,
   output logic [15:0] mem_raddr1,
   output logic        mem_wen,
   output logic [15:0] mem_waddr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata1,
   input  logic        dma_start,
   input  logic        dma_mode,
   input  logic [15:0] dma_src,
   input  logic [15:0] dma_dst,
   input  logic [15:0] dma_len,
   input  logic [15:0] dma_fill,
   output logic        dma_busy,
   output logic        dma_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_RD, S_W1, S_W2, S_WR, S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] buf_q, buf_d;
   logic [15:0] fill_q, fill_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] src_nx, dst_nx;
   logic        dma_rreq, dma_wreq;
`ifdef DMA_BACKWARD_EN
   logic        dir_q, dir_d;
`endif

   always_comb begin
      dma_rreq = (state_q == S_RD);
      dma_wreq = (state_q == S_FILL) || (state_q == S_WR);
`ifdef DMA_BACKWARD_EN
      src_nx = dir_q ? src_q - 16'd1 : src_q + 16'd1;
      dst_nx = dir_q ? dst_q - 16'd1 : dst_q + 16'd1;
`else
      src_nx = src_q + 16'd1;
      dst_nx = dst_q + 16'd1;
`endif
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
`ifdef DMA_BACKWARD_EN
      dir_d   = dir_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (dma_start) begin
               fill_d = dma_fill;
               src_d  = dma_src;
               dst_d  = dma_dst;
               cnt_d  = dma_len;
`ifdef DMA_BACKWARD_EN
               dir_d = dma_mode && (dma_dst > dma_src);
               if (dir_d) begin
                  src_d = dma_src + dma_len - 16'd1;
                  dst_d = dma_dst + dma_len - 16'd1;
               end
`endif
               if (dma_len == 16'd0)
                  state_d = S_FIN;
               else if (dma_mode)
                  state_d = S_RD;
               else
                  state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (!cpu_wen) begin
               dst_d = dst_q + 16'd1;
               cnt_d = cnt_q - 16'd1;
               if (cnt_q == 16'd1)
                  state_d = S_FIN;
            end
         end
         S_RD: begin
            if (!cpu_ren)
               state_d = S_W1;
         end
         S_W1: state_d = S_W2;
         // port 1 data for the granted read is valid exactly now
         S_W2: begin
            buf_d   = mem_rdata1;
            state_d = S_WR;
         end
         S_WR: begin
            if (!cpu_wen) begin
               src_d   = src_nx;
               dst_d   = dst_nx;
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? S_FIN : S_RD;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         fill_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DMA_BACKWARD_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DMA_BACKWARD_EN
         dir_q   <= dir_d;
`endif
      end
   end

   // CPU always owns a port in any cycle it asserts that port's enable
   always_comb begin
      mem_ren    = cpu_ren | dma_rreq;
      mem_raddr1 = cpu_ren ? cpu_raddr : (dma_rreq ? src_q : '0);
      mem_wen    = cpu_wen | dma_wreq;
      mem_waddr  = cpu_wen ? cpu_waddr : (dma_wreq ? dst_q : '0);
      if (cpu_wen)
         mem_wdata = cpu_wdata;
      else if (state_q == S_FILL)
         mem_wdata = fill_q;
      else if (state_q == S_WR)
         mem_wdata = buf_q;
      else
         mem_wdata = '0;
   end

   assign dma_busy = busy_q;
   assign dma_done = done_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: transfer-level model of mem_dma with a 2-cycle read memory,
// random CPU port traffic and directed fill/copy/wrap/abort cases.
`timescale 1ns/1ps
module tb_mem_dma;

   logic        clk, rst;
   logic        cpu_ren, cpu_wen;
   logic [15:0] cpu_raddr, cpu_waddr, cpu_wdata;
   logic        mem_ren, mem_wen;
   logic [15:0] mem_raddr1, mem_waddr, mem_wdata, mem_rdata1;
   logic        dma_start, dma_mode;
   logic [15:0] dma_src, dma_dst, dma_len, dma_fill;
   logic        dma_busy, dma_done;

   mem_dma dut (
      .clk(clk), .rst(rst),
      .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
      .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
      .mem_ren(mem_ren), .mem_raddr1(mem_raddr1),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_rdata1(mem_rdata1),
      .dma_start(dma_start), .dma_mode(dma_mode),
      .dma_src(dma_src), .dma_dst(dma_dst),
      .dma_len(dma_len), .dma_fill(dma_fill),
      .dma_busy(dma_busy), .dma_done(dma_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] bmem [0:65535];
   logic [15:0] rp1, rp2;
   logic        bd_we;
   logic [15:0] bd_addr, bd_data;
   always @(posedge clk) begin
      if (bd_we) bmem[bd_addr] <= bd_data;
      if (mem_wen && mem_waddr < 16'hF000) bmem[mem_waddr] <= mem_wdata;
      rp1 <= bmem[mem_raddr1];
      rp2 <= rp1;
   end
   assign mem_rdata1 = rp2;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // transfer-level model: queue of expected reads/writes plus a coarse phase
   logic [15:0] rdq [$];
   logic [31:0] wrq [$];
   int          ph, np, wt, mn;
   bit          m_copy, m_back;
   logic [15:0] ma, md, mofs;
   logic [31:0] mw;

   initial begin
      ph = 0; wt = 0; m_copy = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ph = 0;
            rdq.delete();
            wrq.delete();
         end else begin
            np = ph;
            if (cpu_ren) begin
               chk("rd_cpu_en", 32'(mem_ren), 1);
               chk("rd_cpu_addr", 32'(mem_raddr1), 32'(cpu_raddr));
            end else if (ph == 1 && rdq.size() > 0) begin
               ma = rdq.pop_front();
               chk("dma_ren", 32'(mem_ren), 1);
               chk("dma_raddr", 32'(mem_raddr1), 32'(ma));
               np = 2;
               wt = 2;
            end else begin
               chk("rd_idle_en", 32'(mem_ren), 0);
               chk("rd_idle_addr", 32'(mem_raddr1), 0);
            end
            if (cpu_wen) begin
               chk("wr_cpu_en", 32'(mem_wen), 1);
               chk("wr_cpu_addr", 32'(mem_waddr), 32'(cpu_waddr));
               chk("wr_cpu_data", 32'(mem_wdata), 32'(cpu_wdata));
            end else if (ph == 3 && wrq.size() > 0) begin
               mw = wrq.pop_front();
               chk("dma_wen", 32'(mem_wen), 1);
               chk("dma_waddr", 32'(mem_waddr), 32'(mw[31:16]));
               chk("dma_wdata", 32'(mem_wdata), 32'(mw[15:0]));
               np = (wrq.size() == 0) ? 4 : (m_copy ? 1 : 3);
            end else begin
               chk("wr_idle_en", 32'(mem_wen), 0);
               chk("wr_idle_addr", 32'(mem_waddr), 0);
               chk("wr_idle_data", 32'(mem_wdata), 0);
            end
            chk("busy", 32'(dma_busy), 32'(ph != 0));
            chk("done", 32'(dma_done), 32'(ph == 4));
            if (ph == 0 && dma_start) begin
               m_copy = dma_mode;
               mn = int'(dma_len);
               m_back = 0;
`ifdef DMA_BACKWARD_EN
               m_back = dma_mode && (dma_dst > dma_src);
`endif
               for (int i = 0; i < mn; i++) begin
                  mofs = m_back ? 16'(mn - 1 - i) : 16'(i);
                  ma = dma_src + mofs;
                  md = dma_dst + mofs;
                  if (dma_mode) begin
                     rdq.push_back(ma);
                     wrq.push_back({md, bmem[ma]});
                  end else begin
                     wrq.push_back({md, dma_fill});
                  end
               end
               np = (mn == 0) ? 4 : (dma_mode ? 1 : 3);
            end else if (ph == 2) begin
               wt--;
               if (wt == 0) np = 3;
            end else if (ph == 4) begin
               np = 0;
            end
            ph = np;
         end
      end
   end

   bit rand_cpu;
   int s_cyc;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_cpu) begin
         cpu_ren   = 1'($urandom_range(0, 1));
         cpu_raddr = 16'($urandom);
         cpu_wen   = ($urandom_range(0, 9) < 4);
         cpu_waddr = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
         cpu_wdata = 16'($urandom);
      end
   endtask

   task automatic start_dma(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input logic [15:0] f);
      tick();
      dma_start = 1'b1;
      dma_mode  = m;
      dma_src   = s;
      dma_dst   = d;
      dma_len   = n;
      dma_fill  = f;
      s_cyc     = cyc;
      tick();
      dma_start = 1'b0;
   endtask

   task automatic wait_done(output int cy);
      bit seen;
      seen = 0;
      cy = -1;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (dma_done) begin
            seen = 1;
            cy = cyc - s_cyc;
         end else begin
            tick();
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      bd_we = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
   endtask

   int cy;
   logic        rm;
   logic [15:0] rs, rd, rl;

   initial begin
      rst = 1'b1;
      rand_cpu = 0;
      cpu_ren = 0; cpu_wen = 0;
      cpu_raddr = 0; cpu_waddr = 0; cpu_wdata = 0;
      dma_start = 0; dma_mode = 0;
      dma_src = 0; dma_dst = 0; dma_len = 0; dma_fill = 0;
      bd_we = 0; bd_addr = 0; bd_data = 0;
      for (int i = 0; i < 8192; i++) begin
         @(posedge clk);
         #1;
         bd_we = 1'b1;
         bd_addr = 16'(i);
         bd_data = 16'(i) ^ 16'hC3C3;
      end
      bd_write(16'h0100, 16'h00A1);
      bd_write(16'h0101, 16'h00A2);
      bd_write(16'h0102, 16'h00A3);
      for (int i = 0; i < 4; i++) bd_write(16'h0200 + 16'(i), 16'(i + 1));
      chk("reset_busy", 32'(dma_busy), 0);
      chk("reset_done", 32'(dma_done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // fill with idle CPU
      start_dma(0, 16'h0000, 16'hE000, 16'd4, 16'h1234);
      wait_done(cy);
      chk("fill_done_cyc", cy, 5);
      for (int i = 0; i < 4; i++)
         chk("fill_mem", 32'(bmem[16'hE000 + 16'(i)]), 32'h1234);

      // CPU write wins S+2, DMA write slips one cycle
      start_dma(0, 16'h0000, 16'hE000, 16'd4, 16'h4321);
      tick();
      cpu_wen = 1; cpu_waddr = 16'h0010; cpu_wdata = 16'hBEEF;
      tick();
      cpu_wen = 0;
      wait_done(cy);
      chk("prio_done_cyc", cy, 6);
      chk("prio_cpu_mem", 32'(bmem[16'h0010]), 32'hBEEF);
      chk("prio_dma_mem", 32'(bmem[16'hE001]), 32'h4321);

      // copy with a CPU read during W1 of the first word
      start_dma(1, 16'h0100, 16'hC000, 16'd3, 16'h0000);
      tick();
      cpu_ren = 1; cpu_raddr = 16'h0000;
      tick();
      cpu_ren = 0;
      wait_done(cy);
      chk("copy_done_cyc", cy, 13);
      for (int i = 0; i < 3; i++)
         chk("copy_mem", 32'(bmem[16'hC000 + 16'(i)]), 32'hA1 + 32'(i));

      // zero length
      start_dma(0, 16'h0000, 16'hA000, 16'd0, 16'h7777);
      wait_done(cy);
      chk("zero_done_cyc", cy, 1);

      // restart while busy is ignored
      start_dma(0, 16'h0000, 16'h9100, 16'd3, 16'h1111);
      dma_start = 1; dma_dst = 16'h9200; dma_len = 16'd5; dma_fill = 16'h2222;
      tick();
      dma_start = 0;
      wait_done(cy);
      chk("restart_done_cyc", cy, 4);
      chk("restart_mem", 32'(bmem[16'h9102]), 32'h1111);

      // address wrap
      start_dma(0, 16'h0000, 16'hFFFF, 16'd2, 16'h5555);
      wait_done(cy);
      chk("wrap_done_cyc", cy, 3);
      chk("wrap_mem0", 32'(bmem[16'h0000]), 32'h5555);

      // abort mid-copy
      start_dma(1, 16'h0100, 16'hC100, 16'd3, 16'h0000);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(dma_busy), 0);
      chk("abort_done", 32'(dma_done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef DMA_BACKWARD_EN
      start_dma(1, 16'h0200, 16'h0201, 16'd4, 16'h0000);
      wait_done(cy);
      chk("overlap_done_cyc", cy, 17);
      for (int i = 0; i < 4; i++)
         chk("overlap_mem", 32'(bmem[16'h0201 + 16'(i)]), 32'(i + 1));
`endif

      rand_cpu = 1;
      for (int k = 0; k < 40; k++) begin
         rm = 1'($urandom_range(0, 1));
         rl = 16'($urandom_range(0, 6));
         rs = 16'h1000 | 16'($urandom_range(0, 12'hFF0));
         rd = (rm ? 16'h8000 : 16'h9000) | 16'($urandom_range(0, 12'hFF0));
         start_dma(rm, rs, rd, rl, 16'($urandom));
         wait_done(cy);
      end
      rand_cpu = 0;
      cpu_ren = 0;
      cpu_wen = 0;
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_dma.md
# mem_dma

Block-transfer engine that shares the memory's second read port (port 1) and its single write port between the CPU and a DMA sequencer. It sits between the CPU load/store path and `mem`, and performs word fills and word copies anywhere in the 16-bit address space, typically framebuffer clears and tile uploads. The CPU always wins a conflicting cycle. The DMA uses only idle port slots, so the CPU is never stalled.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_ren`  in  1  CPU read request on port 1.
- `cpu_raddr`  in  16  CPU read address.
- `cpu_wen`  in  1  CPU write request.
- `cpu_waddr`  in  16  CPU write address.
- `cpu_wdata`  in  16  CPU write data.
- `mem_ren`  out  1  to `mem` `ren`.
- `mem_raddr1`  out  16  to `mem` `raddr1`.
- `mem_wen`  out  1  to `mem` `wen`.
- `mem_waddr`  out  16  to `mem` `waddr`.
- `mem_wdata`  out  16  to `mem` `wdata`.
- `mem_rdata1`  in  16  from `mem` `rdata1`; valid 2 cycles after the address is presented.
- `dma_start`  in  1  single-cycle pulse; latches all config inputs below.
- `dma_mode`  in  1  0 = fill, 1 = copy.
- `dma_src`  in  16  copy source base address.
- `dma_dst`  in  16  destination base address.
- `dma_len`  in  16  word count.
- `dma_fill`  in  16  fill value.
- `dma_busy`  out  1  high from the cycle after an accepted start until completion.
- `dma_done`  out  1  single-cycle pulse on completion.

## Operation
- **Port mux.** The mux is combinational. `mem_ren`, `mem_raddr1` and `mem_wen`/`mem_waddr`/`mem_wdata` carry the CPU signals whenever the CPU asserts the corresponding enable. Otherwise they carry the DMA request, or zero when the DMA is idle.
- **Slot rule.** A DMA read is granted only in a cycle with `cpu_ren`=0. A DMA write is granted only in a cycle with `cpu_wen`=0. An ungranted request is held unchanged to the next cycle.
- **States:** IDLE, FILL, RD, W1, W2, WR, FIN.
- **IDLE:**
  - On `dma_start` the block latches the config and loads `src`, `dst` and `cnt`=`dma_len`.
  - `len`=0 → FIN, with no memory access.
  - Otherwise `mode`=0 → FILL and `mode`=1 → RD.
  - `dma_start` outside IDLE is ignored.
- **FILL:**
  - Each granted write stores `fill` at `dst`, then sets `dst`+=1 and `cnt`-=1.
  - When `cnt` reaches 1 and that write is granted → FIN.
- **RD:**
  - Presents `src` with `mem_ren`=1.
  - When granted → W1.
  - When not granted, stays in RD.
- **W1** → W2, unconditionally.
- **W2:** captures `mem_rdata1` into `buf` → WR.
- **WR:**
  - Each granted write stores `buf` at `dst`, then sets `src`+=1, `dst`+=1 and `cnt`-=1.
  - If the new `cnt` is 0 → FIN, else → RD.
- **FIN:** pulses `dma_done` → IDLE.
- **Address arithmetic** is 16-bit modulo: 0xFFFF+1 = 0x0000, with no error.
- **No range checks.** Writes at or above 0xF000 are issued and `mem` discards them. Reads return whatever `mem` returns.
- **Overlap.** Copy is ascending. When `dst` lies in (`src`, `src`+`len`), the result is defined only with `DMA_BACKWARD_EN` (see Configuration).

## Timing
- **Reset values:** state=IDLE; `dma_busy`=0, `dma_done`=0; `buf`, `src`, `dst` and `cnt` all 0.
- **Reset mid-transfer** aborts immediately with no `dma_done`. A write already clocked into `mem` stays.
- **Mux outputs with no requests** are all 0.
- **Fill** with no CPU conflicts:
  - Writes occur on cycles S+1 … S+len, where S is the start cycle.
  - `dma_done` is high at cycle S+len+1.
  - `dma_busy` is high on S+1 … S+len+1.
- **Copy** takes 4 cycles per word without conflicts. `dma_done` is high at cycle S+4·len+1.
- **Read latency.** The W1/W2 wait is exactly 2 cycles after the granted read. A CPU read in W1 or W2 does not disturb `buf`, because port 1 data is captured exactly at W2.
- **Zero length.** `len`=0 gives `dma_done` at S+1.

## Configuration
- **`DMA_BACKWARD_EN` defined:**
  - A copy whose `dst` > `src` starts at `src`+`len`−1 and `dst`+`len`−1, and decrements both addresses (modulo 16-bit).
  - This applies to copies only; fill always ascends.
  - Overlapping copies then produce memmove semantics.
- **`DMA_BACKWARD_EN` undefined:** copies always ascend, and the backward logic is absent.

## Test plan
- **Fill with idle CPU.** Fill `dst`=0xE000, `len`=4, `fill`=0x1234 → writes at 0xE000–0xE003 on S+1…S+4; `dma_done` at S+5; framebuffer reads back 0x1234.
- **CPU write priority.** Same fill with `cpu_wen`=1 on S+2 (addr 0x0010, data 0xBEEF) → CPU write lands at 0x0010; DMA write of 0xE001 deferred to S+3; `dma_done` at S+6.
- **Copy with a CPU read in W1.** Copy `src`=0x0100 → `dst`=0xC000, `len`=3, with preloaded 0xA1/0xA2/0xA3 → tilemap 0xC000–0xC002 reads 0xA1/0xA2/0xA3. A `cpu_ren` at 0x0000 in a W1 cycle delays nothing and corrupts nothing.
- **Zero length and ignored restart.**
  - `len`=0 → `dma_done` at S+1; `mem_wen` never driven by the DMA.
  - A second `dma_start` while busy is ignored and its config is not latched.
- **Wrap and abort.**
  - Fill `dst`=0xFFFF, `len`=2 → second write address is 0x0000.
  - `rst` asserted mid-copy → `dma_busy`=0 and `dma_done`=0 at once; state returns to IDLE.
- **Overlapping copy (`DMA_BACKWARD_EN` defined).** `src`=0x0200 holds 1,2,3,4; copy to `dst`=0x0201, `len`=4 → 0x0201–0x0204 reads 1,2,3,4.
